// File: rtl/core_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: formats, field bundle and the
// immediate range check used ahead of the pipeline.
package core_encoder_pkg;

   typedef struct packed {
      int unsigned XLEN;
   } config_t;

   localparam config_t CONF_DEFAULT = '{XLEN: 32};

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_t;

   typedef logic [6:0] opcode_t;
   typedef logic [2:0] funct3_t;
   typedef logic [6:0] funct7_t;

   typedef struct packed {
      fmt_t       fmt;
      opcode_t    op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      funct3_t    funct3;
      funct7_t    funct7;
      logic [31:0] imm;
   } fields_t;

   // True when the immediate cannot be represented by the format, the opcode is
   // not a 32-bit encoding, or the format tag is out of range.
   function automatic logic range_err(input fmt_t fmt, input opcode_t op,
                                      input logic [31:0] imm);
      logic bad;
      case (fmt)
         FMT_R:        bad = 1'b0;
         FMT_I, FMT_S: bad = imm[31:11] != {21{imm[11]}};
         FMT_B:        bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
         FMT_U:        bad = imm[11:0] != 12'd0;
         FMT_J:        bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
         default:      bad = 1'b1;
      endcase
      return bad || (op[1:0] != 2'b11);
   endfunction

endpackage

// File: rtl/core_encoder_if.sv
// Field-in / word-out handshake bundle of the instruction encoder, plus flush
// and the delivery counters.
interface core_encoder_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) ();
   logic                        flush;
   logic                        in_valid;
   logic                        in_ready;
   core_encoder_pkg::fmt_t      in_fmt;
   core_encoder_pkg::opcode_t   in_op;
   logic [4:0]                  in_rd;
   logic [4:0]                  in_rs1;
   logic [4:0]                  in_rs2;
   core_encoder_pkg::funct3_t   in_funct3;
   core_encoder_pkg::funct7_t   in_funct7;
   logic [XLEN-1:0]             in_imm;
   logic                        out_valid;
   logic                        out_ready;
   logic [XLEN-1:0]             out_inst;
   logic                        out_err;
   logic [CNT_W-1:0]            enc_cnt;
   logic [CNT_W-1:0]            err_cnt;

   modport master (
      output flush, in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_err, enc_cnt, err_cnt
   );

   modport slave (
      input  flush, in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_err, enc_cnt, err_cnt
   );
endinterface

// File: rtl/core_encoder_pack.sv
// Combinational packer: lays the registered fields out as an RV32I word.
// Illegal format tags fall back to the R layout.
module core_encoder_pack
   import core_encoder_pkg::*;
(
   input  fields_t     f,
   output logic [31:0] inst
);

   always_comb begin
      inst = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.op};
      case (f.fmt)
         FMT_I: inst = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.op};
         FMT_S: inst = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.op};
         FMT_B: inst = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                        f.imm[4:1], f.imm[11], f.op};
         FMT_U: inst = {f.imm[31:12], f.rd, f.op};
         FMT_J: inst = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                        f.rd, f.op};
         default: ;
      endcase
   end

endmodule

// File: rtl/core_encoder.sv
// Two-stage RV32I encoder: S1 holds fields and range check, S2 holds the packed
// word. Skid-free back-pressure, synchronous flush, delivery counters.
module core_encoder
   import core_encoder_pkg::*;
#(
   parameter config_t CONF  = CONF_DEFAULT,
   parameter int      CNT_W = 16
) (
   input logic           clk,
   input logic           rst_n,
   core_encoder_if.slave bus
);

   localparam int XLEN = int'(CONF.XLEN);

   fields_t           in_f;
   fields_t           s1_f;
   logic              s1_valid;
   logic              s1_err;
   logic [31:0]       pk_inst;
   logic [XLEN-1:0]   s2_inst;
   logic              s2_valid;
   logic              s2_err;
   logic              s1_adv;
   logic              s2_adv;
   logic              deliver;
   logic [CNT_W-1:0]  enc_q;
   logic [CNT_W-1:0]  err_q;

   assign in_f = '{fmt: bus.in_fmt, op: bus.in_op, rd: bus.in_rd,
                   rs1: bus.in_rs1, rs2: bus.in_rs2, funct3: bus.in_funct3,
                   funct7: bus.in_funct7, imm: bus.in_imm};

   assign s2_adv  = !s2_valid || bus.out_ready;
   assign s1_adv  = !s1_valid || s2_adv;
   assign deliver = s2_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_f     <= '0;
         s1_err   <= 1'b0;
      end else if (bus.flush) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_f   <= in_f;
            s1_err <= range_err(in_f.fmt, in_f.op, in_f.imm);
         end
      end
   end

   core_encoder_pack u_pack (
      .f    (s1_f),
      .inst (pk_inst)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_inst  <= '0;
         s2_err   <= 1'b0;
      end else if (bus.flush) begin
         s2_valid <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_inst <= pk_inst;
            s2_err  <= s1_err;
         end
      end
   end

   // A word handed over in the flush cycle was seen by the consumer, so it counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_q <= '0;
         err_q <= '0;
      end else if (deliver) begin
         enc_q <= enc_q + 1'b1;
         if (s2_err && (err_q != '1))
            err_q <= err_q + 1'b1;
      end
   end

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_valid;
   assign bus.out_inst  = s2_inst;
   assign bus.out_err   = s2_err;
   assign bus.enc_cnt   = enc_q;
   assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_core_encoder.sv
// Randomized and directed checks of core_encoder against a queue-based model.
module tb_core_encoder;
   import core_encoder_pkg::*;

   typedef struct {
      logic [31:0] w;
      logic        e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   core_encoder_if #(.XLEN(32), .CNT_W(16)) bus ();
   core_encoder #(.CONF(CONF_DEFAULT), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        q[$];
   logic [15:0] m_enc = 16'd0;
   int          m_err = 0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_w = 32'd0;
   logic        hold_e = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference encoding straight from the field layout, using shifts and masks.
   function automatic exp_t model(input fields_t f);
      exp_t        r;
      int unsigned u, op, rd, r1, r2, f3, f7;
      int          s;
      u = f.imm; s = int'(signed'(f.imm));
      op = f.op; rd = f.rd; r1 = f.rs1; r2 = f.rs2; f3 = f.funct3; f7 = f.funct7;
      case (int'(f.fmt))
         1: begin
            r.w = ((u & 'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
            r.e = (s < -2048) || (s > 2047);
         end
         2: begin
            r.w = (((u >> 5) & 'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                | ((u & 'h1F) << 7) | op;
            r.e = (s < -2048) || (s > 2047);
         end
         3: begin
            r.w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (r2 << 20)
                | (r1 << 15) | (f3 << 12) | (((u >> 1) & 'hF) << 8)
                | (((u >> 11) & 1) << 7) | op;
            r.e = (s < -4096) || (s > 4095) || ((u & 1) != 0);
         end
         4: begin
            r.w = (u & 'hFFFFF000) | (rd << 7) | op;
            r.e = (u & 'hFFF) != 0;
         end
         5: begin
            r.w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21)
                | (((u >> 11) & 1) << 20) | (((u >> 12) & 'hFF) << 12) | (rd << 7) | op;
            r.e = (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((u & 1) != 0);
         end
         default: begin
            r.w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
            r.e = int'(f.fmt) > 5;
         end
      endcase
      if ((op & 3) != 3) r.e = 1'b1;
      return r;
   endfunction

   function automatic fields_t mk(input fmt_t fmt, input int op, input int rd, input int rs1,
                                  input int rs2, input int f3, input int f7, input int imm);
      fields_t f;
      f.fmt = fmt; f.op = 7'(op); f.rd = 5'(rd); f.rs1 = 5'(rs1); f.rs2 = 5'(rs2);
      f.funct3 = 3'(f3); f.funct7 = 7'(f7); f.imm = 32'(imm);
      return f;
   endfunction

   function automatic logic [31:0] rnd_imm();
      int s;
      case ($urandom_range(0, 6))
         0: s = int'($urandom_range(0, 32)) - 16;
         1: s = 2047 + int'($urandom_range(0, 1)) - 4098 * int'($urandom_range(0, 1));
         2: s = 4094 + int'($urandom_range(0, 3)) - 8190 * int'($urandom_range(0, 1));
         3: s = (1 << 20) - 2 + int'($urandom_range(0, 3)) - (1 << 21) * int'($urandom_range(0, 1));
         4: s = int'($urandom() & 32'hFFFFF000);
         5: s = int'($urandom_range(0, 1)) + 2 * (int'($urandom_range(0, 4000)) - 2000);
         default: s = int'($urandom());
      endcase
      return 32'(s);
   endfunction

   function automatic fields_t rnd_fields();
      fields_t f;
      f.fmt = ($urandom_range(0, 9) == 0) ? fmt_t'(3'($urandom_range(6, 7)))
                                          : fmt_t'(3'($urandom_range(0, 5)));
      f.op = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : {5'($urandom()), 2'b11};
      f.rd = 5'($urandom()); f.rs1 = 5'($urandom()); f.rs2 = 5'($urandom());
      f.funct3 = 3'($urandom()); f.funct7 = 7'($urandom());
      f.imm = rnd_imm();
      return f;
   endfunction

   task automatic apply(input fields_t f);
      bus.in_fmt = f.fmt; bus.in_op = f.op; bus.in_rd = f.rd; bus.in_rs1 = f.rs1;
      bus.in_rs2 = f.rs2; bus.in_funct3 = f.funct3; bus.in_funct7 = f.funct7;
      bus.in_imm = f.imm;
   endtask

   function automatic fields_t cur_fields();
      fields_t f;
      f.fmt = bus.in_fmt; f.op = bus.in_op; f.rd = bus.in_rd; f.rs1 = bus.in_rs1;
      f.rs2 = bus.in_rs2; f.funct3 = bus.in_funct3; f.funct7 = bus.in_funct7;
      f.imm = bus.in_imm;
      return f;
   endfunction

   // Every cycle: counters, in_ready, held outputs, and delivered words vs the queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete(); m_enc = 16'd0; m_err = 0; hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_inst", bus.out_inst, hold_w);
            chk("hold_err", 32'(bus.out_err), 32'(hold_e));
         end
         chk("enc_cnt", 32'(bus.enc_cnt), 32'(m_enc));
         chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
         chk("in_ready", 32'(bus.in_ready), 32'(bus.out_ready || (q.size() < 2)));
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_word", 32'(q.size()), 32'd1);
            end else begin
               e = q.pop_front();
               chk("word_inst", bus.out_inst, e.w);
               chk("word_err", 32'(bus.out_err), 32'(e.e));
               m_enc++;
               if (e.e && m_err < 65535) m_err++;
            end
         end
         hold_v = bus.out_valid && !bus.out_ready && !bus.flush;
         hold_w = bus.out_inst;
         hold_e = bus.out_err;
         if (bus.flush) q.delete();
         else if (bus.in_valid && bus.in_ready) q.push_back(model(cur_fields()));
      end
   end

   task automatic push(input fields_t f);
      bit ok;
      ok = 1'b0;
      apply(f);
      bus.in_valid = 1'b1;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      chk("push_accept", 32'(ok), 32'd1);
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (q.size() == 0 && !bus.out_valid) break;
      end
      chk("drain_done", 32'(k < 100), 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Single word into an empty pipeline with out_ready high: latency and literal word.
   task automatic direct(input string name, input fields_t f, input logic [31:0] w,
                         input logic e);
      int k;
      apply(f);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      chk({name, "_latency"}, 32'(k), 32'd2);
      chk({name, "_inst"}, bus.out_inst, w);
      chk({name, "_err"}, 32'(bus.out_err), 32'(e));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      apply(mk(FMT_R, 'h33, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_inst", bus.out_inst, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      chk("rst_enc_cnt", 32'(bus.enc_cnt), 32'd0);
      chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
      @(posedge clk);
      #1;

      direct("addi", mk(FMT_I, 'h13, 1, 0, 0, 0, 0, 5), 32'h00500093, 1'b0);
      direct("sw", mk(FMT_S, 'h23, 0, 1, 2, 2, 0, 8), 32'h0020A423, 1'b0);
      direct("beq", mk(FMT_B, 'h63, 0, 0, 0, 0, 0, -4), 32'hFE000EE3, 1'b0);
      direct("lui", mk(FMT_U, 'h37, 5, 0, 0, 0, 0, 'h12345000), 32'h123452B7, 1'b0);
      direct("jal", mk(FMT_J, 'h6F, 1, 0, 0, 0, 0, 2048), 32'h001000EF, 1'b0);
      direct("add", mk(FMT_R, 'h33, 3, 1, 2, 0, 0, 0), 32'h002081B3, 1'b0);
      direct("addi_big", mk(FMT_I, 'h13, 1, 0, 0, 0, 0, 2048), 32'h80000093, 1'b1);
      direct("b_odd", mk(FMT_B, 'h63, 0, 0, 0, 0, 0, 3), 32'h00000163, 1'b1);
      direct("u_low", mk(FMT_U, 'h37, 5, 0, 0, 0, 0, 'h12345001), 32'h123452B7, 1'b1);
      direct("bad_fmt", mk(fmt_t'(3'd6), 'h33, 3, 1, 2, 0, 0, 0), 32'h002081B3, 1'b1);
      direct("bad_op", mk(FMT_I, 'h10, 1, 0, 0, 0, 0, 5), 32'h00500090, 1'b1);
      chk("dir_enc_cnt", 32'(bus.enc_cnt), 32'd11);
      chk("dir_err_cnt", 32'(bus.err_cnt), 32'd5);

      // Back-pressure: 5 words, consumer stalled for 4 cycles.
      do_reset();
      bus.out_ready = 1'b0;
      fork
         for (int i = 0; i < 5; i++) push(mk(FMT_I, 'h13, i + 1, 0, 0, 0, 0, i * 3));
         begin
            repeat (4) @(posedge clk);
            #1 chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            chk("bp_held_inst", bus.out_inst, 32'h00000093);
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_enc_cnt", 32'(bus.enc_cnt), 32'd5);

      // Flush with two words in flight, then flush alongside a fresh input.
      bus.out_ready = 1'b0;
      push(mk(FMT_U, 'h37, 2, 0, 0, 0, 0, 'h1000));
      push(mk(FMT_U, 'h37, 3, 0, 0, 0, 0, 'h2000));
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      apply(mk(FMT_U, 'h37, 4, 0, 0, 0, 0, 'h3000));
      bus.in_valid = 1'b1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("flush_no_out", 32'(bus.out_valid), 32'd0);
      end
      chk("flush_enc_cnt", 32'(bus.enc_cnt), 32'd5);
      @(posedge clk);
      #1;

      // Randomized traffic with random stalls and occasional flush.
      for (int c = 0; c < 1500; c++) begin
         apply(rnd_fields());
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush = ($urandom_range(0, 31) == 0);
         @(posedge clk);
         #1;
      end
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      drain();

      // Reset while words are held in the pipeline.
      bus.out_ready = 1'b0;
      push(mk(FMT_I, 'h13, 7, 1, 0, 0, 0, 100));
      push(mk(FMT_I, 'h13, 8, 1, 0, 0, 0, 4000));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_inst", bus.out_inst, 32'd0);
      chk("mid_rst_err", 32'(bus.out_err), 32'd0);
      chk("mid_rst_enc", 32'(bus.enc_cnt), 32'd0);
      chk("mid_rst_errc", 32'(bus.err_cnt), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Saturation of err_cnt and wrap of enc_cnt.
      apply(mk(FMT_U, 'h37, 1, 0, 0, 0, 0, 1));
      bus.in_valid = 1'b1;
      repeat (65535) @(posedge clk);
      #1 bus.in_valid = 1'b0;
      drain();
      chk("sat_err_cnt", 32'(bus.err_cnt), 32'h0000FFFF);
      chk("sat_enc_cnt", 32'(bus.enc_cnt), 32'h0000FFFF);
      direct("sat_last", mk(FMT_U, 'h37, 1, 0, 0, 0, 0, 1), 32'h000000B7, 1'b1);
      chk("sat_err_hold", 32'(bus.err_cnt), 32'h0000FFFF);
      chk("wrap_enc_cnt", 32'(bus.enc_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/core_encoder.md
Name: core_encoder

Overview:
- Pipelined RV32I instruction encoder; the inverse of the core's field decoder.
- Accepts decoded fields plus a format tag and emits the packed 32-bit instruction word, with valid/ready handshakes on both sides.
- Used by the boot/self-test loader and the instruction-memory preload path to generate instruction streams.
- Flags immediates that the selected format cannot represent.

Parameters:
CONF, config_t default from config_pkg, core configuration; CONF.XLEN must be 32.
CNT_W, 16, width of the emitted-word and error counters.

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous pipeline clear
in_valid  in  1  input fields valid
in_ready  out  1  encoder can accept fields
in_fmt  in  fmt_t(3)  instruction format: R, I, S, B, U, J
in_op  in  opcode_t(7)  opcode
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  funct3_t(3)  funct3
in_funct7  in  funct7_t(7)  funct7
in_imm  in  CONF.XLEN  full signed immediate value (not pre-shifted)
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts word
out_inst  out  CONF.XLEN  encoded instruction
out_err  out  1  word was encoded from an unrepresentable field
enc_cnt  out  CNT_W  words delivered, wraps
err_cnt  out  CNT_W  errored words delivered, saturates

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: all valid bits 0, out_inst 0, out_err 0, enc_cnt 0, err_cnt 0. in_ready is 1 once rst_n deasserts.
- Pipeline stages:
  - S1 registers the fields, the format and the range-check result.
  - S2 registers the packed word and the error flag.
  - Latency from input accept to out_valid: exactly 2 cycles when unstalled.
  - Throughput: 1 word per cycle.
- Flow control:
  - S2 advances when !s2_valid or out_ready.
  - S1 advances when !s1_valid or S2 advances.
  - in_ready is S1's advance condition; it is combinational from out_ready only.
  - No bubble is inserted when the stall releases. Stalled outputs hold stable.
- Packing, word bits listed from MSB to LSB:
  - R: funct7 | rs2 | rs1 | funct3 | rd | op
  - I: imm[11:0] | rs1 | funct3 | rd | op
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | op
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | op
  - U: imm[31:12] | rd | op
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op
  - Fields a format does not use are ignored.
- Error rules (any one sets err):
  - I/S: imm is not the sign-extension of imm[11:0].
  - B: imm is not the sign-extension of imm[12:0], or imm[0]=1.
  - J: imm is not the sign-extension of imm[20:0], or imm[0]=1.
  - U: imm[11:0] != 0.
  - Any format: op[1:0] != 2'b11.
  - in_fmt encoding is illegal.
- Error handling:
  - The word is still packed from truncated bits.
  - An illegal fmt packs as R.
  - out_err is asserted with the word.
- Counters:
  - Update only on out_valid && out_ready.
  - enc_cnt wraps modulo 2^CNT_W.
  - err_cnt increments only when out_err=1 and holds at all-ones.
- flush:
  - Clears s1_valid and s2_valid on the next edge; counters are unaffected.
  - An input presented in the same cycle as flush is dropped.
  - flush has priority over advance.
- Reset mid-stream: all in-flight words are lost immediately (asynchronous); nothing is emitted after release until new input arrives.

Decomposition:
- opcodes_pkg: fmt_t enum (FMT_R=0 through FMT_J=5), plus packing and range-check functions shared with tests.
- One natural sub-module, core_encoder_pack: combinational packer and range checker, instantiated between S1 and S2.
- The pipeline registers and counters stay in core_encoder.

Test Plan:
- I, addi x1,x0,5: op 0x13, rd 1, funct3 0, imm 5 -> out_inst 0x00500093, out_err 0, out_valid exactly 2 cycles after accept.
- S/B: sw x2,8(x1) -> 0x0020A423; beq x0,x0 with imm -4 -> 0xFE000EE3.
- U/J: lui x5 with imm 0x12345000 -> 0x123452B7; jal x1 with imm 2048 -> 0x001000EF.
- Errors:
  - addi with imm 2048 -> out_inst 0x80000093, out_err 1, err_cnt +1.
  - B with imm 3 -> out_err 1.
  - U with imm 0x12345001 -> out_err 1.
- Back-pressure:
  - Stream 5 words with out_ready low for 4 cycles -> in_ready drops after 2 words are held, the held word stays stable, and all 5 arrive in order.
  - enc_cnt = 5.
- flush / reset:
  - flush while 2 words are in flight -> neither emerges; counters unchanged.
  - rst_n low mid-stream -> outputs and counters read 0 in the same cycle.
  - err_cnt preloaded by 65535 errored words plus 1 more -> holds 0xFFFF.
